// File: rtl/game_pkg.sv
// Shared constants and helpers for the On-The-Run lane game controller.
// Contents: FSM state encoding, lane window bounds (signed 10-bit car
// offsets), LFSR seed/tap mask, screen size, and two small helper functions.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPAWN = 3'd1;
    localparam logic [2:0] ST_FALL  = 3'd2;
    localparam logic [2:0] ST_CRASH = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    // Polynomial x^8 + x^6 + x^5 + x^4 + 1; bit 7 is tap 8.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic signed [9:0] LANE0_MIN = -10'sd242;
    localparam logic signed [9:0] LANE0_MAX = -10'sd154;
    localparam logic signed [9:0] LANE1_MIN = -10'sd130;
    localparam logic signed [9:0] LANE1_MAX = -10'sd29;
    localparam logic signed [9:0] LANE2_MIN = -10'sd10;
    localparam logic signed [9:0] LANE2_MAX = 10'sd78;
    localparam logic signed [9:0] LANE3_MIN = 10'sd80;
    localparam logic signed [9:0] LANE3_MAX = 10'sd135;

    // True when the car offset lies inside the (inclusive) window of a lane.
    function automatic logic lane_window_hit(input logic [1:0] lane,
                                             input logic signed [9:0] x);
        logic in_win;
        case (lane)
            2'd0:    in_win = (x >= LANE0_MIN) && (x <= LANE0_MAX);
            2'd1:    in_win = (x >= LANE1_MIN) && (x <= LANE1_MAX);
            2'd2:    in_win = (x >= LANE2_MIN) && (x <= LANE2_MAX);
            default: in_win = (x >= LANE3_MIN) && (x <= LANE3_MAX);
        endcase
        return in_win;
    endfunction

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick obstacle lanes.
// Ports: clk, reset (sync, active-high, loads seed), seed (reload value),
//        lfsr_out (current register value). Advances every clock cycle.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] lfsr_out
);

    logic [7:0] lfsr_d;
    logic [7:0] lfsr_q;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/lane_game_sequencer.sv
// Top-level round sequencer for the On-The-Run game: drops one obstacle at a
// time into a pseudo-random lane, detects collisions with the car, keeps the
// score and fall speed.
// Inputs : clk, reset (sync, active-high), tick (game-step enable),
//          start_n (active-low start button), player_x (signed car offset).
// Outputs: move_en, obs_valid, obs_lane, obs_y, oncollision, check (one-hot
//          lane while in hit band), dead (active-low), score, state.
module lane_game_sequencer
    import game_pkg::*;
#(
    parameter int HIT_Y_MIN   = 350,
    parameter int HIT_Y_MAX   = 460,
    parameter int BOTTOM_Y    = SCREEN_H,
    parameter int SPEED_INIT  = 2,
    parameter int SPEED_MAX   = 8,
    parameter int SPEED_STEP  = 5,
    parameter int CRASH_TICKS = 60
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_n,
    input  logic [9:0] player_x,
    output logic       move_en,
    output logic       obs_valid,
    output logic [1:0] obs_lane,
    output logic [8:0] obs_y,
    output logic       oncollision,
    output logic [3:0] check,
    output logic       dead,
    output logic [7:0] score,
    output logic [2:0] state
);

    localparam logic [8:0] HIT_MIN    = 9'(HIT_Y_MIN);
    localparam logic [8:0] HIT_MAX    = 9'(HIT_Y_MAX);
    localparam logic [8:0] BOTTOM     = 9'(BOTTOM_Y);
    localparam logic [3:0] SPD_INIT   = 4'(SPEED_INIT);
    localparam logic [3:0] SPD_MAX    = 4'(SPEED_MAX);
    localparam logic [2:0] STEP_LAST  = 3'(SPEED_STEP - 1);
    localparam logic [5:0] CRASH_LAST = 6'(CRASH_TICKS - 1);

    logic [2:0] state_q, state_d;
    logic       move_en_q, move_en_d;
    logic       obs_valid_q, obs_valid_d;
    logic [1:0] obs_lane_q, obs_lane_d;
    logic [8:0] obs_y_q, obs_y_d;
    logic       oncollision_q, oncollision_d;
    logic [3:0] check_q, check_d;
    logic       dead_q, dead_d;
    logic [7:0] score_q, score_d;
    logic [3:0] speed_q, speed_d;
    logic [2:0] step_q, step_d;
    logic [5:0] crash_cnt_q, crash_cnt_d;
    logic       start_prev_q, start_prev_d;

    logic       start_press;
    logic       hit;
    logic       crash;
    logic [7:0] lfsr_value;

    lfsr8 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .seed     (LFSR_SEED),
        .lfsr_out (lfsr_value)
    );

    always_comb begin
        state_d       = state_q;
        obs_valid_d   = obs_valid_q;
        obs_lane_d    = obs_lane_q;
        obs_y_d       = obs_y_q;
        oncollision_d = oncollision_q;
        check_d       = check_q;
        dead_d        = dead_q;
        score_d       = score_q;
        speed_d       = speed_q;
        step_d        = step_q;
        crash_cnt_d   = crash_cnt_q;
        start_prev_d  = start_n;

        start_press = start_prev_q & ~start_n;
        hit         = (obs_y_q >= HIT_MIN) && (obs_y_q <= HIT_MAX);
        crash       = hit && lane_window_hit(obs_lane_q, $signed(player_x));

        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d = ST_SPAWN;
                    score_d = 8'd0;
                    speed_d = SPD_INIT;
                    step_d  = 3'd0;
                    dead_d  = 1'b1;
                end
            end
            ST_SPAWN: begin
                obs_lane_d  = lfsr_value[1:0];
                obs_y_d     = 9'd0;
                obs_valid_d = 1'b1;
                state_d     = ST_FALL;
            end
            ST_FALL: begin
                oncollision_d = hit;
                check_d       = hit ? lane_onehot(obs_lane_q) : 4'b0000;
                // Crash takes precedence over both retire and the tick
                // advance so the obstacle freezes where it hit the car.
                if (crash) begin
                    state_d     = ST_CRASH;
                    dead_d      = 1'b0;
                    crash_cnt_d = 6'd0;
                end else if (obs_y_q >= BOTTOM) begin
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    obs_valid_d = 1'b0;
                    state_d     = ST_SPAWN;
                    if (step_q == STEP_LAST) begin
                        step_d = 3'd0;
                        if (speed_q < SPD_MAX) begin
                            speed_d = speed_q + 4'd1;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else if (tick) begin
                    obs_y_d = obs_y_q + {5'd0, speed_q};
                end
            end
            ST_CRASH: begin
                if (tick) begin
                    if (crash_cnt_q == CRASH_LAST) begin
                        crash_cnt_d   = 6'd0;
                        obs_valid_d   = 1'b0;
                        check_d       = 4'b0000;
                        oncollision_d = 1'b0;
                        state_d       = ST_OVER;
                    end else begin
                        crash_cnt_d = crash_cnt_q + 6'd1;
                    end
                end
            end
            ST_OVER: begin
                if (start_press) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the next state so move_en lines up with state.
        move_en_d = (state_d == ST_SPAWN) || (state_d == ST_FALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            move_en_q     <= 1'b0;
            obs_valid_q   <= 1'b0;
            obs_lane_q    <= 2'd0;
            obs_y_q       <= 9'd0;
            oncollision_q <= 1'b0;
            check_q       <= 4'b0000;
            dead_q        <= 1'b1;
            score_q       <= 8'd0;
            speed_q       <= SPD_INIT;
            step_q        <= 3'd0;
            crash_cnt_q   <= 6'd0;
            start_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            move_en_q     <= move_en_d;
            obs_valid_q   <= obs_valid_d;
            obs_lane_q    <= obs_lane_d;
            obs_y_q       <= obs_y_d;
            oncollision_q <= oncollision_d;
            check_q       <= check_d;
            dead_q        <= dead_d;
            score_q       <= score_d;
            speed_q       <= speed_d;
            step_q        <= step_d;
            crash_cnt_q   <= crash_cnt_d;
            start_prev_q  <= start_prev_d;
        end
    end

    assign state       = state_q;
    assign move_en     = move_en_q;
    assign obs_valid   = obs_valid_q;
    assign obs_lane    = obs_lane_q;
    assign obs_y       = obs_y_q;
    assign oncollision = oncollision_q;
    assign check       = check_q;
    assign dead        = dead_q;
    assign score       = score_q;

endmodule

// File: tb/tb_lane_game_sequencer.sv
// Self-checking bench for lane_game_sequencer: a vector table for the reset
// and start sequence, directed multi-cycle scenarios (lane pass, crash,
// window edges, speed ramp, score saturation, mid-round reset) and a
// randomized run, all compared against a cycle-level game model.
module tb_lane_game_sequencer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start_n;
    logic [9:0] player_x;
    logic       move_en;
    logic       obs_valid;
    logic [1:0] obs_lane;
    logic [8:0] obs_y;
    logic       oncollision;
    logic [3:0] check;
    logic       dead;
    logic [7:0] score;
    logic [2:0] state;

    lane_game_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start_n     (start_n),
        .player_x    (player_x),
        .move_en     (move_en),
        .obs_valid   (obs_valid),
        .obs_lane    (obs_lane),
        .obs_y       (obs_y),
        .oncollision (oncollision),
        .check       (check),
        .dead        (dead),
        .score       (score),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int S_IDLE = 0, S_SPAWN = 1, S_FALL = 2, S_CRASH = 3, S_OVER = 4;
    localparam int SAFE_X = -140;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int cur_px   = 0;

    // Game model: plain integers describing what the screen/HUD should show.
    int m_state, m_lane, m_y, m_valid, m_onc, m_check, m_dead, m_move;
    int m_score, m_speed, m_passed, m_crash_ticks, m_lfsr, m_prev;
    int win_lo[4] = '{-242, -130, -10, 80};
    int win_hi[4] = '{-154, -29, 78, 135};

    typedef struct {
        logic       rst;
        logic       sn;
        logic       tk;
        int         px;
        logic [2:0] e_state;
        logic       e_move;
        logic       e_valid;
        logic [8:0] e_y;
        logic       e_dead;
        logic [7:0] e_score;
    } vec_t;

    vec_t vecs[10];

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic modelStep();
        int n_state, n_lane, n_y, n_valid, n_onc, n_check, n_dead;
        int n_score, n_speed, n_passed, n_ct;
        bit press, in_band;
        if (reset) begin
            m_state = S_IDLE; m_lane = 0; m_y = 0; m_valid = 0; m_onc = 0;
            m_check = 0; m_dead = 1; m_move = 0; m_score = 0; m_speed = 2;
            m_passed = 0; m_crash_ticks = 0; m_lfsr = 8'hA5; m_prev = 1;
            return;
        end
        n_state = m_state; n_lane = m_lane; n_y = m_y; n_valid = m_valid;
        n_onc = m_onc; n_check = m_check; n_dead = m_dead; n_score = m_score;
        n_speed = m_speed; n_passed = m_passed; n_ct = m_crash_ticks;
        press = (m_prev == 1) && (start_n == 1'b0);
        case (m_state)
            S_IDLE: if (press) begin
                n_state = S_SPAWN; n_score = 0; n_speed = 2; n_passed = 0; n_dead = 1;
            end
            S_SPAWN: begin
                n_lane = m_lfsr % 4; n_y = 0; n_valid = 1; n_state = S_FALL;
            end
            S_FALL: begin
                in_band = (m_y >= 350) && (m_y <= 460);
                n_onc   = in_band;
                n_check = in_band ? (1 << m_lane) : 0;
                if (in_band && cur_px >= win_lo[m_lane] && cur_px <= win_hi[m_lane]) begin
                    n_state = S_CRASH; n_dead = 0; n_ct = 0;
                end else if (m_y >= 480) begin
                    n_score  = (m_score < 255) ? m_score + 1 : 255;
                    n_valid  = 0;
                    n_state  = S_SPAWN;
                    n_passed = m_passed + 1;
                    if (n_passed == 5) begin
                        n_passed = 0;
                        n_speed  = (m_speed + 1 > 8) ? 8 : m_speed + 1;
                    end
                end else if (tick) begin
                    n_y = m_y + m_speed;
                end
            end
            S_CRASH: if (tick) begin
                n_ct = m_crash_ticks + 1;
                if (n_ct == 60) begin
                    n_valid = 0; n_check = 0; n_onc = 0; n_state = S_OVER;
                end
            end
            default: if (press) n_state = S_IDLE;
        endcase
        m_state = n_state; m_lane = n_lane; m_y = n_y; m_valid = n_valid;
        m_onc = n_onc; m_check = n_check; m_dead = n_dead; m_score = n_score;
        m_speed = n_speed; m_passed = n_passed; m_crash_ticks = n_ct;
        m_move = (n_state == S_SPAWN || n_state == S_FALL) ? 1 : 0;
        m_lfsr = lfsr_next(m_lfsr);
        m_prev = start_n;
    endtask

    task automatic compareModel();
        logic [29:0] act, exp;
        act = {state, move_en, obs_valid, obs_lane, obs_y, oncollision, check, dead, score};
        exp = {3'(m_state), 1'(m_move), 1'(m_valid), 2'(m_lane), 9'(m_y),
               1'(m_onc), 4'(m_check), 1'(m_dead), 8'(m_score)};
        checkOutput("outputs_vs_model", int'(act), int'(exp));
    endtask

    // One clock cycle: drive inputs, let the edge happen, step the model, compare.
    task automatic applyStimulus(input logic r, input logic sn, input logic tk, input int px);
        reset    = r;
        start_n  = sn;
        tick     = tk;
        player_x = 10'(px);
        cur_px   = px;
        @(posedge clk);
        modelStep();
        #1;
        cycle++;
        compareModel();
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, SAFE_X);
        applyStimulus(1'b0, 1'b1, 1'b0, SAFE_X);
    endtask

    // Times the start press so the first obstacle lands in the wanted lane.
    task automatic startRoundWithLane(input int lane, input int px);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            if ((lfsr_next(m_lfsr) & 3) == lane) begin
                found = 1;
                break;
            end
            applyStimulus(1'b0, 1'b1, 1'b0, px);
        end
        checkOutput("lane_search_done", int'(found), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, px);
        applyStimulus(1'b0, 1'b1, 1'b0, px);
        checkOutput("spawn_lane", obs_lane, lane);
    endtask

    task automatic runUntilScore(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (score == 8'(target)) break;
            applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        end
        checkOutput($sformatf("reach_score_%0d", target), score, target);
    endtask

    initial begin
        int n_band;
        reset = 1'b1; start_n = 1'b1; tick = 1'b0; player_x = '0;

        // Reset, start press, ignored press during FALL, mid-round reset.
        vecs[0] = '{1'b1, 1'b1, 1'b0, SAFE_X, 3'd0, 1'b0, 1'b0, 9'd0, 1'b1, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, SAFE_X, 3'd0, 1'b0, 1'b0, 9'd0, 1'b1, 8'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, SAFE_X, 3'd0, 1'b0, 1'b0, 9'd0, 1'b1, 8'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, SAFE_X, 3'd0, 1'b0, 1'b0, 9'd0, 1'b1, 8'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, SAFE_X, 3'd1, 1'b1, 1'b0, 9'd0, 1'b1, 8'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, SAFE_X, 3'd2, 1'b1, 1'b1, 9'd0, 1'b1, 8'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, SAFE_X, 3'd2, 1'b1, 1'b1, 9'd2, 1'b1, 8'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, SAFE_X, 3'd2, 1'b1, 1'b1, 9'd2, 1'b1, 8'd0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, SAFE_X, 3'd2, 1'b1, 1'b1, 9'd4, 1'b1, 8'd0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, SAFE_X, 3'd0, 1'b0, 1'b0, 9'd0, 1'b1, 8'd0};

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sn, vecs[i].tk, vecs[i].px);
            checkOutput($sformatf("vec%0d", i),
                        int'({state, move_en, obs_valid, obs_y, dead, score}),
                        int'({vecs[i].e_state, vecs[i].e_move, vecs[i].e_valid,
                              vecs[i].e_y, vecs[i].e_dead, vecs[i].e_score}));
            if (i == 2) checkOutput("lfsr_reset_seed", dut.lfsr_value, 8'hA5);
        end

        $display("[TB] lane 2 pass with player_x=+120");
        applyStimulus(1'b0, 1'b1, 1'b0, 120);
        startRoundWithLane(2, 120);
        n_band = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 120);
            if (oncollision === 1'b1 && check === 4'b0100) n_band++;
            if (state == 3'(S_SPAWN)) break;
        end
        checkOutput("lane2_band_cycles", n_band, 56);
        checkOutput("lane2_score", score, 1);
        checkOutput("lane2_respawn_state", state, S_SPAWN);

        $display("[TB] lane 0 crash with player_x=-200");
        resetDut();
        startRoundWithLane(0, -200);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, -200);
            if (obs_y >= 9'd350) break;
        end
        checkOutput("crash_first_band_y", obs_y, 350);
        checkOutput("crash_dead_before", dead, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, -200);
        checkOutput("crash_dead", dead, 0);
        checkOutput("crash_state", state, S_CRASH);
        checkOutput("crash_y_frozen", obs_y, 350);
        checkOutput("crash_move_en", move_en, 0);
        for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b1, 1'b1, -200);
        checkOutput("crash_hold_59", state, S_CRASH);
        checkOutput("crash_valid_held", obs_valid, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, -200);
        checkOutput("over_state", state, S_OVER);
        checkOutput("over_check", check, 0);
        checkOutput("over_valid", obs_valid, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, -200);
        checkOutput("over_to_idle", state, S_IDLE);
        checkOutput("idle_dead_still_low", dead, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, -200);
        applyStimulus(1'b0, 1'b0, 1'b0, -200);
        checkOutput("restart_state", state, S_SPAWN);
        checkOutput("restart_dead", dead, 1);

        $display("[TB] lane 0 window edge");
        resetDut();
        startRoundWithLane(0, -153);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, -153);
            if (state != 3'(S_FALL)) break;
        end
        checkOutput("edge_m153_state", state, S_SPAWN);
        checkOutput("edge_m153_score", score, 1);
        resetDut();
        startRoundWithLane(0, -154);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, -154);
            if (state != 3'(S_FALL)) break;
        end
        checkOutput("edge_m154_state", state, S_CRASH);

        $display("[TB] speed ramp and score saturation");
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, SAFE_X);
        runUntilScore(5, 2000);
        applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        checkOutput("speed3_step", obs_y, 3);
        runUntilScore(35, 8000);
        applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        checkOutput("speed8_cap_step", obs_y, 8);
        runUntilScore(255, 20000);
        applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
            if (state == 3'(S_SPAWN)) break;
        end
        checkOutput("score_saturate", score, 255);
        checkOutput("sat_respawn_state", state, S_SPAWN);

        $display("[TB] reset during FALL");
        applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        for (int i = 0; i < 100; i++) begin
            if (obs_y == 9'd200) break;
            applyStimulus(1'b0, 1'b1, 1'b1, SAFE_X);
        end
        checkOutput("pre_reset_y", obs_y, 200);
        applyStimulus(1'b1, 1'b1, 1'b1, SAFE_X);
        checkOutput("mid_reset_state", state, S_IDLE);
        checkOutput("mid_reset_y", obs_y, 0);
        checkOutput("mid_reset_dead", dead, 1);
        checkOutput("mid_reset_score", score, 0);
        checkOutput("mid_reset_lfsr", dut.lfsr_value, 8'hA5);

        $display("[TB] randomized run");
        applyStimulus(1'b0, 1'b1, 1'b0, SAFE_X);
        cur_px = SAFE_X;
        for (int i = 0; i < 4000; i++) begin
            int px;
            px = cur_px;
            if ($urandom_range(0, 39) == 0) px = int'($urandom_range(0, 390)) - 255;
            applyStimulus(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1,
                          1'($urandom_range(0, 1)),
                          px);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
